// File: rtl/chroni_text_fetch_if.sv
// Memory read port and line-buffer write port of the chroni text fetcher.
// The master side is the fetcher; the slave side is memory plus line buffer.
interface chroni_text_fetch_if #(
  parameter int ADDR_W    = 16,
  parameter int LB_ADDR_W = 11
) ();
  logic [ADDR_W-1:0]    addr_out;
  logic                 rd_req;
  logic                 rd_ack;
  logic [7:0]           data_in;
  logic                 wr_en;
  logic [LB_ADDR_W-1:0] wr_addr;
  logic [7:0]           wr_bitmap;
  logic [3:0]           wr_fg;
  logic [3:0]           wr_bg;
  logic                 wr_busy;

  modport master (
    output addr_out, rd_req, wr_en, wr_addr, wr_bitmap, wr_fg, wr_bg,
    input  rd_ack, data_in, wr_busy
  );
  modport slave (
    input  addr_out, rd_req, wr_en, wr_addr, wr_bitmap, wr_fg, wr_bg,
    output rd_ack, data_in, wr_busy
  );
endinterface

// File: rtl/chroni_text_fetch.sv
// Text-mode scanline fetcher: character codes, optional attributes, then one glyph byte per column.
// Define CHRONI_TEXT_ATTR_EN to fetch per-character colour attributes.
module chroni_text_fetch #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter int         FONT_ROWS_LOG2 = 3,
  parameter int         ADDR_W         = 16,
  parameter int         LB_ADDR_W      = 11,
  parameter int         LB_HALF        = 640,
  parameter logic [3:0] DEF_FG         = 4'hF,
  parameter logic [3:0] DEF_BG         = 4'h0
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                buf_sel,
  input  logic [ADDR_W-1:0]   text_base,
  input  logic [ADDR_W-1:0]   attr_base,
  input  logic [ADDR_W-1:0]   font_base,
  chroni_text_fetch_if.master bus,
  output logic                busy,
  output logic                line_done,
  output logic                overrun
);
  localparam int               COL_W    = $clog2(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [7:0]       ROW_LAST = 8'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE,
    TXT_REQ,
    TXT_WAIT,
`ifdef CHRONI_TEXT_ATTR_EN
    ATT_REQ,
    ATT_WAIT,
`endif
    GLY_REQ,
    GLY_WAIT,
    WR,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic                      buf_q, buf_d;
  logic                      busy_q, busy_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      rd_req_q, rd_req_d;
  logic [7:0]                bitmap_q, bitmap_d;
  logic [LB_ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [3:0]                fg_q, fg_d, bg_q, bg_d;
  logic                      line_done_q, line_done_d;
  logic                      overrun_q, overrun_d;
  logic [FONT_ROWS_LOG2-1:0] scan_q, scan_d;
  logic [7:0]                row_q, row_d;
  logic [ADDR_W-1:0]         row_addr_q, row_addr_d;
  logic [ADDR_W-1:0]         tbase_q, tbase_d;
  logic                      char_we, wr_en;
  logic [7:0]                char_buf_q [COLS];
  logic                      col_last;
  logic [LB_ADDR_W-1:0]      half_off;
`ifdef CHRONI_TEXT_ATTR_EN
  logic [ADDR_W-1:0]         arow_addr_q, arow_addr_d;
  logic [ADDR_W-1:0]         abase_q, abase_d;
  logic                      attr_we;
  logic [7:0]                attr_buf_q [COLS];
`else
  logic                      unused_attr_base;
  assign unused_attr_base = ^attr_base;
`endif

  assign col_last = (col_q == COL_LAST);
  assign half_off = buf_q ? LB_ADDR_W'(LB_HALF) : '0;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (line_start) state_d = (scan_q == '0) ? TXT_REQ : GLY_REQ;
      TXT_REQ:  state_d = TXT_WAIT;
`ifdef CHRONI_TEXT_ATTR_EN
      TXT_WAIT: if (bus.rd_ack) state_d = ATT_REQ;
      ATT_REQ:  state_d = ATT_WAIT;
      ATT_WAIT: if (bus.rd_ack) state_d = col_last ? GLY_REQ : TXT_REQ;
`else
      TXT_WAIT: if (bus.rd_ack) state_d = col_last ? GLY_REQ : TXT_REQ;
`endif
      GLY_REQ:  state_d = GLY_WAIT;
      GLY_WAIT: if (bus.rd_ack) state_d = WR;
      WR:       if (!bus.wr_busy) state_d = DONE;
      DONE:     state_d = col_last ? IDLE : GLY_REQ;
      default:  state_d = IDLE;
    endcase
    // Frame abort wins over everything; a coincident line_start begins row 0, scan 0.
    if (frame_start) state_d = line_start ? TXT_REQ : IDLE;
  end

  always_comb begin
    col_d       = col_q;
    buf_d       = buf_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    rd_req_d    = rd_req_q;
    bitmap_d    = bitmap_q;
    wr_addr_d   = wr_addr_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    line_done_d = 1'b0;
    overrun_d   = line_start && busy_q;
    scan_d      = scan_q;
    row_d       = row_q;
    row_addr_d  = row_addr_q;
    tbase_d     = tbase_q;
    char_we     = 1'b0;
    wr_en       = 1'b0;
`ifdef CHRONI_TEXT_ATTR_EN
    arow_addr_d = arow_addr_q;
    abase_d     = abase_q;
    attr_we     = 1'b0;
`endif
    case (state_q)
      IDLE: if (line_start) begin
        buf_d  = buf_sel;
        col_d  = '0;
        busy_d = 1'b1;
      end
      TXT_REQ: begin
        addr_d   = row_addr_q + ADDR_W'(col_q);
        rd_req_d = 1'b1;
      end
      TXT_WAIT: if (bus.rd_ack) begin
        rd_req_d = 1'b0;
        char_we  = 1'b1;
`ifndef CHRONI_TEXT_ATTR_EN
        col_d    = col_last ? '0 : col_q + COL_W'(1);
`endif
      end
`ifdef CHRONI_TEXT_ATTR_EN
      ATT_REQ: begin
        addr_d   = arow_addr_q + ADDR_W'(col_q);
        rd_req_d = 1'b1;
      end
      ATT_WAIT: if (bus.rd_ack) begin
        rd_req_d = 1'b0;
        attr_we  = 1'b1;
        col_d    = col_last ? '0 : col_q + COL_W'(1);
      end
`endif
      GLY_REQ: begin
        addr_d   = font_base | ADDR_W'({char_buf_q[col_q], scan_q});
        rd_req_d = 1'b1;
      end
      GLY_WAIT: if (bus.rd_ack) begin
        rd_req_d  = 1'b0;
        bitmap_d  = bus.data_in;
        wr_addr_d = half_off + LB_ADDR_W'({col_q, 3'b000});
`ifdef CHRONI_TEXT_ATTR_EN
        fg_d      = attr_buf_q[col_q][7:4];
        bg_d      = attr_buf_q[col_q][3:0];
`else
        fg_d      = DEF_FG;
        bg_d      = DEF_BG;
`endif
      end
      WR: wr_en = !bus.wr_busy;
      DONE: if (!col_last) begin
        col_d = col_q + COL_W'(1);
      end else begin
        line_done_d = 1'b1;
        busy_d      = 1'b0;
        if (&scan_q) begin
          scan_d = '0;
          if (row_q == ROW_LAST) begin
            row_d      = '0;
            row_addr_d = tbase_q;
`ifdef CHRONI_TEXT_ATTR_EN
            arow_addr_d = abase_q;
`endif
          end else begin
            row_d      = row_q + 8'd1;
            row_addr_d = row_addr_q + ADDR_W'(COLS);
`ifdef CHRONI_TEXT_ATTR_EN
            arow_addr_d = arow_addr_q + ADDR_W'(COLS);
`endif
          end
        end else begin
          scan_d = scan_q + FONT_ROWS_LOG2'(1);
        end
      end
      default: ;
    endcase
    if (frame_start) begin
      rd_req_d    = 1'b0;
      busy_d      = line_start;
      col_d       = '0;
      buf_d       = line_start ? buf_sel : buf_q;
      line_done_d = 1'b0;
      overrun_d   = 1'b0;
      scan_d      = '0;
      row_d       = '0;
      row_addr_d  = text_base;
      tbase_d     = text_base;
      char_we     = 1'b0;
      wr_en       = 1'b0;
`ifdef CHRONI_TEXT_ATTR_EN
      arow_addr_d = attr_base;
      abase_d     = attr_base;
      attr_we     = 1'b0;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      buf_q       <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      rd_req_q    <= 1'b0;
      bitmap_q    <= '0;
      wr_addr_q   <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      scan_q      <= '0;
      row_q       <= '0;
      row_addr_q  <= '0;
      tbase_q     <= '0;
`ifdef CHRONI_TEXT_ATTR_EN
      arow_addr_q <= '0;
      abase_q     <= '0;
`endif
    end else begin
      col_q       <= col_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      rd_req_q    <= rd_req_d;
      bitmap_q    <= bitmap_d;
      wr_addr_q   <= wr_addr_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
      scan_q      <= scan_d;
      row_q       <= row_d;
      row_addr_q  <= row_addr_d;
      tbase_q     <= tbase_d;
`ifdef CHRONI_TEXT_ATTR_EN
      arow_addr_q <= arow_addr_d;
      abase_q     <= abase_d;
`endif
    end
  end

  // Row buffers hold only fetched data and need no reset.
  always_ff @(posedge sys_clk) begin
    if (char_we) char_buf_q[col_q] <= bus.data_in;
`ifdef CHRONI_TEXT_ATTR_EN
    if (attr_we) attr_buf_q[col_q] <= bus.data_in;
`endif
  end

  assign bus.addr_out  = addr_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_bitmap = bitmap_q;
  assign bus.wr_fg     = fg_q;
  assign bus.wr_bg     = bg_q;
  assign busy          = busy_q;
  assign line_done     = line_done_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_chroni_text_fetch.sv
// Directed bench for chroni_text_fetch: 4 columns, 2 rows, 8-line font, 1-cycle-latency memory.
module tb_chroni_text_fetch;
  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start  = 1'b0;
  logic        buf_sel     = 1'b0;
  logic [15:0] text_base   = 16'h1000;
  logic [15:0] attr_base   = 16'h2000;
  logic [15:0] font_base   = 16'h4000;
  logic        busy, line_done, overrun;
  int          n_checks = 0;
  int          n_err    = 0;

`ifdef CHRONI_TEXT_ATTR_EN
  localparam logic [3:0] FG0 = 4'h1, BG0 = 4'hE, FG1 = 4'h2, BG1 = 4'hC;
  localparam int N_TXT = 8;
`else
  localparam logic [3:0] FG0 = 4'hF, BG0 = 4'h0, FG1 = 4'hF, BG1 = 4'h0;
  localparam int N_TXT = 4;
`endif

  chroni_text_fetch_if #(.ADDR_W(16), .LB_ADDR_W(11)) bus ();

  chroni_text_fetch #(
    .COLS(4), .ROWS(2), .FONT_ROWS_LOG2(3), .ADDR_W(16), .LB_ADDR_W(11),
    .LB_HALF(640), .DEF_FG(4'hF), .DEF_BG(4'h0)
  ) dut (
    .sys_clk(clk), .reset_n(rst_n), .frame_start(frame_start), .line_start(line_start),
    .buf_sel(buf_sel), .text_base(text_base), .attr_base(attr_base), .font_base(font_base),
    .bus(bus), .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Memory model: ack in the second cycle of each request, data valid with the ack.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log [$];
  always @(posedge clk) begin
    if (!rst_n) bus.rd_ack <= 1'b0;
    else begin
      bus.rd_ack <= bus.rd_req && !bus.rd_ack;
      if (bus.rd_req && !bus.rd_ack) rd_log.push_back(bus.addr_out);
    end
    bus.data_in <= mem[bus.addr_out];
  end

  logic [10:0] wa_q [$];
  logic [7:0]  bm_q [$];
  logic [3:0]  fg_q [$];
  logic [3:0]  bg_q [$];
  int   ld_cnt = 0, ov_cnt = 0, bf_cnt = 0, busy_viol = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      bm_q.push_back(bus.wr_bitmap);
      fg_q.push_back(bus.wr_fg);
      bg_q.push_back(bus.wr_bg);
      if (bus.wr_busy) busy_viol++;
    end
    if (line_done) ld_cnt++;
    if (overrun) ov_cnt++;
    if (busy_prev && !busy) bf_cnt++;
    busy_prev = busy;
  end

  function automatic logic [7:0] font_byte(input int a);
    return 8'((a - 'h4000) * 7 + 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wa_q.delete(); bm_q.delete(); fg_q.delete(); bg_q.delete();
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic start_line(input logic b);
    @(posedge clk); #1 line_start = 1'b1; buf_sel = b;
    @(posedge clk); #1 line_start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ld_cnt != n0) return;
    end
    check("line_done_timeout", ld_cnt, n0 + 1);
  endtask

  task automatic run_line(input logic b);
    int n0;
    n0 = ld_cnt;
    start_line(b);
    wait_done(n0);
    @(negedge clk);
  endtask

  task automatic wait_gly(input logic want_ack, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rd_req && bus.addr_out[14] && (bus.rd_ack == want_ack)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_rd [$];
    logic        ok;
    int          ld0, ov0, bf0, nw;

    bus.wr_busy = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int c = 0; c < 4; c++) begin
      mem[16'h1000 + c] = 8'h41 + 8'(c);
      mem[16'h1004 + c] = 8'h50 + 8'(c);
      mem[16'h2000 + c] = 8'h1E;
      mem[16'h2004 + c] = 8'h2C;
    end
    for (int a = 'h4000; a < 'h4800; a++) mem[a] = font_byte(a);

    repeat (3) @(negedge clk);
    check("rst_rd_req",  bus.rd_req, 0);
    check("rst_addr",    bus.addr_out, 0);
    check("rst_wr_en",   bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_bitmap",  bus.wr_bitmap, 0);
    check("rst_fg_bg",   {bus.wr_fg, bus.wr_bg}, 0);
    check("rst_flags",   {busy, line_done, overrun}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Row 0, scan 0, buffer half 0
`ifdef CHRONI_TEXT_ATTR_EN
    exp_rd = '{16'h1000, 16'h2000, 16'h1001, 16'h2001, 16'h1002, 16'h2002, 16'h1003, 16'h2003,
               16'h4208, 16'h4210, 16'h4218, 16'h4220};
`else
    exp_rd = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h4208, 16'h4210, 16'h4218, 16'h4220};
`endif
    pulse_frame();
    clear_logs();
    ld0 = ld_cnt;
    run_line(1'b0);
    check("t1_nreads", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      check($sformatf("t1_rd%0d", i), (i < rd_log.size()) ? rd_log[i] : 16'hDEAD, exp_rd[i]);
    check("t1_nwr", wa_q.size(), 4);
    for (int c = 0; c < wa_q.size(); c++) begin
      check($sformatf("t1_wa%0d", c), wa_q[c], 8 * c);
      check($sformatf("t1_bm%0d", c), bm_q[c], font_byte('h4208 + 8 * c));
      check($sformatf("t1_fg%0d", c), fg_q[c], FG0);
      check($sformatf("t1_bg%0d", c), bg_q[c], BG0);
    end
    check("t1_line_done", ld_cnt - ld0, 1);

    // Scanlines 1..7 of row 0 fetch glyphs only
    for (int s = 1; s < 8; s++) begin
      clear_logs();
      run_line(1'b0);
      check($sformatf("t2_gly_s%0d", s), (rd_log.size() > 0) ? rd_log[0] : 16'h0, 16'h4208 + s);
      check($sformatf("t2_n_s%0d", s), rd_log.size(), 4);
    end
    clear_logs();
    run_line(1'b0);
    check("t2_row1_txt", (rd_log.size() > 0) ? rd_log[0] : 16'h0, 16'h1004);
    check("t2_row1_gly", (rd_log.size() > N_TXT) ? rd_log[N_TXT] : 16'h0, 16'h4280);
    check("t2_row1_fgbg", (fg_q.size() > 0) ? {fg_q[0], bg_q[0]} : 8'h0, {FG1, BG1});
    for (int s = 1; s < 8; s++) run_line(1'b0);
    clear_logs();
    run_line(1'b0);
    check("t2_wrap_txt", (rd_log.size() > 0) ? rd_log[0] : 16'h0, 16'h1000);

    // Buffer half 1 with the line buffer busy on every write
    pulse_frame();
    bus.wr_busy = 1'b1;
    clear_logs();
    ld0 = ld_cnt;
    start_line(1'b1);
    for (int c = 0; c < 4; c++) begin
      wait_gly(1'b1, ok);
      check($sformatf("t3_ack%0d", c), ok, 1);
      nw = wa_q.size();
      repeat (5) @(posedge clk);
      @(posedge clk); #1;
      check($sformatf("t3_held%0d", c), wa_q.size(), nw);
      bus.wr_busy = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 bus.wr_busy = 1'b1;
      check($sformatf("t3_wr%0d", c), wa_q.size(), nw + 1);
    end
    bus.wr_busy = 1'b0;
    wait_done(ld0);
    check("t3_nwr", wa_q.size(), 4);
    for (int c = 0; c < wa_q.size(); c++) begin
      check($sformatf("t3_wa%0d", c), wa_q[c], 640 + 8 * c);
      check($sformatf("t3_fgbg%0d", c), {fg_q[c], bg_q[c]}, {FG0, BG0});
    end

    // line_start during the glyph phase is rejected
    clear_logs();
    ld0 = ld_cnt; ov0 = ov_cnt; bf0 = bf_cnt;
    start_line(1'b0);
    wait_gly(1'b1, ok);
    check("t4_ack", ok, 1);
    @(posedge clk); #1 line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    wait_done(ld0);
    repeat (3) @(negedge clk);
    check("t4_overrun", ov_cnt - ov0, 1);
    check("t4_nwr", wa_q.size(), 4);
    check("t4_busy_fall", bf_cnt - bf0, 1);
    check("t4_line_done", ld_cnt - ld0, 1);

    // Frame abort while a glyph read is outstanding
    ld0 = ld_cnt;
    start_line(1'b0);
    wait_gly(1'b0, ok);
    check("t5_req", ok, 1);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    check("t5_rd_req", bus.rd_req, 0);
    check("t5_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("t5_no_done", ld_cnt, ld0);
    clear_logs();
    run_line(1'b0);
    check("t5_txt", (rd_log.size() > 0) ? rd_log[0] : 16'h0, 16'h1000);
    check("t5_gly", (rd_log.size() > N_TXT) ? rd_log[N_TXT] : 16'h0, 16'h4208);
    check("t5_nreads", rd_log.size(), N_TXT + 4);

    check("wr_while_busy", busy_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
